ram_sp_rsp: RTL and testbench
=============================

// Module: ram_sp_rsp
// PURPOSE
//  Responder end of the single-port RAM access protocol (addr/we/oe/wdata in, read data out).
//  Owns a DEPTH x DW synchronous single-port store and serves one request per cycle from a
//  sequencing initiator (write bursts, then read-back). Adds valid/ready flow control, a
//  2-entry read-response queue, out-of-range detection and access counters.
// PARAMETERS
//  AW     8    address width
//  DW     8    data width
//  DEPTH  256  implemented words (<= 2**AW); addresses >= DEPTH are out of range
//  CW     16   width of access counters
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted this cycle when req_valid && req_ready
//  req_we     in   1   write request
//  req_oe     in   1   read request (honoured only when req_we=0)
//  req_addr   in   AW  word address
//  req_wdata  in   DW  write data
//  rsp_valid  out  1   read response present
//  rsp_ready  in   1   consumer takes response when rsp_valid && rsp_ready
//  rsp_rdata  out  DW  read data
//  rsp_err    out  1   response belongs to out-of-range read (rsp_rdata = 0)
//  wr_cnt     out  CW  accepted in-range writes, wraps modulo 2**CW
//  rd_cnt     out  CW  accepted reads (incl. out-of-range), wraps modulo 2**CW
// BEHAVIOUR
//  - Reset (sampled at edge): queue emptied, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_cnt=rd_cnt=0.
//    req_ready=0 while reset=1. RAM contents are NOT cleared and survive reset.
//    Reset mid-operation discards queued/pending responses; no response for them ever appears.
//  - req_ready = !reset && (queue count < 2); purely from registered state, no path from rsp_ready.
//  - Decode of accepted request: we=1 -> write (oe ignored; write wins); we=0,oe=1 -> read;
//    we=0,oe=0 -> no-op, accepted and dropped, no counter change, no response.
//  - Write: mem[addr] <= wdata at accepting edge; no response. Out-of-range write dropped silently,
//    wr_cnt unchanged.
//  - Read: mem[addr] sampled at accepting edge into queue tail (read-before-write is impossible:
//    one request per cycle). Response visible (rsp_valid=1) the cycle after acceptance when queue was
//    empty or head is popped that same edge: latency 1, throughput 1/cycle with rsp_ready held 1.
//    Read of an address written at an earlier edge returns the new data.
//  - Out-of-range read: queued with rdata=0, err=1; rd_cnt increments.
//  - Queue: 2-entry FIFO of {err,rdata}, in-order. Push and pop on same edge allowed at any count
//    (count unchanged). rsp_rdata/rsp_err held stable while rsp_valid && !rsp_ready.
//    rsp_rdata/rsp_err = 0 whenever rsp_valid = 0.
//  - Full (count=2): req_ready=0; requests held by initiator; no loss, no overwrite.
//  - Counters wrap 2**CW-1 -> 0 silently.
// TESTING
//  1 Reset: assert reset 3 cycles -> req_ready=0, rsp_valid=0, counters 0; req_ready=1 cycle after.
//  2 Burst write addr 0..3 data 2,4,6,8 then reads addr 0..3, rsp_ready=1 -> rsp 2,4,6,8 each one
//    cycle after its accept, back-to-back, rsp_err=0; wr_cnt=4, rd_cnt=4.
//  3 rsp_ready=0, 3 reads issued -> 2 accepted, req_ready=0, rsp_rdata frozen; release -> 3rd
//    accepted, all 3 delivered in order.
//  4 req_we=1,req_oe=1 addr 5 data 0xA5 -> write only, no rsp; then read 5 -> 0xA5.
//    req_we=0,req_oe=0 -> accepted, no response, counters unchanged.
//  5 DEPTH=16: write addr 20 data 0x55 -> wr_cnt unchanged; read addr 20 -> rsp 0, rsp_err=1.
//  6 Reset with 2 responses queued -> rsp_valid=0 next cycle, none delivered; read addr 0 -> still 2.

Source files
------------

// File: rtl/ram_sp_rsp_if.sv
// Request/response bundle between a RAM-sequencing initiator and the ram_sp_rsp responder.
// The counters travel with the bundle so that one connection carries the whole observable state.
interface ram_sp_rsp_if #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_oe;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;

  modport master (
    output req_valid, req_we, req_oe, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_cnt, rd_cnt
  );

  modport slave (
    input  req_valid, req_we, req_oe, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_cnt, rd_cnt
  );
endinterface

// File: rtl/ram_sp_rsp.sv
// Single-port RAM responder: one request per cycle, reads land in a 2-entry response FIFO,
// out-of-range accesses are flagged, accepted writes/reads are counted.
module ram_sp_rsp #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int CW    = 16
) (
  input  logic        clk,
  input  logic        reset,
  ram_sp_rsp_if.slave io_bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q_data [2];
  logic          r_q_err [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;

  logic          w_ready;
  logic          w_accept;
  logic          w_in_range;
  logic          w_write;
  logic          w_push;
  logic          w_pop;
  logic          w_rsp_valid;
  logic [IW-1:0] w_idx;
  logic [AW:0]   w_addr_ext;
  logic [DW-1:0] w_rd_data;

  // Readiness depends only on stored occupancy and reset, never on the consumer's rsp_ready.
  assign w_ready     = !reset && (r_count < 2'd2);
  assign w_accept    = io_bus.req_valid && w_ready;
  assign w_addr_ext  = {1'b0, io_bus.req_addr};
  assign w_in_range  = w_addr_ext < (AW + 1)'(DEPTH);
  assign w_idx       = io_bus.req_addr[IW-1:0];
  assign w_write     = w_accept && io_bus.req_we && w_in_range;
  assign w_push      = w_accept && !io_bus.req_we && io_bus.req_oe;
  assign w_rsp_valid = (r_count != 2'd0);
  assign w_pop       = w_rsp_valid && io_bus.rsp_ready;
  assign w_rd_data   = w_in_range ? r_mem[w_idx] : '0;

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[w_idx] <= io_bus.req_wdata;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_q_entry
    always_ff @(posedge clk) begin
      if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_q_data[gi] <= w_rd_data;
        r_q_err[gi]  <= !w_in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_write) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_bus.req_ready = w_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_rdata = w_rsp_valid ? r_q_data[r_rd_ptr] : '0;
  assign io_bus.rsp_err   = w_rsp_valid ? r_q_err[r_rd_ptr] : 1'b0;
  assign io_bus.wr_cnt    = r_wr_cnt;
  assign io_bus.rd_cnt    = r_rd_cnt;
endmodule

// File: tb/tb_ram_sp_rsp.sv
// Bench for ram_sp_rsp: directed scenarios then random traffic, every cycle compared against
// a queue/array reference model of the responder.
module tb_ram_sp_rsp;
  localparam int AW = 8, DW = 8, DEPTH = 16, CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_sp_rsp_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  ram_sp_rsp #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  typedef struct {
    bit       err;
    bit [7:0] data;
  } rsp_t;

  rsp_t      mq[$];
  bit [7:0]  mmem [DEPTH];
  bit [15:0] m_wr = 0;
  bit [15:0] m_rd = 0;
  int        n_checks = 0;
  int        n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (mq.size() != 0);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(v));
    chk("rsp_rdata", 32'(bus.rsp_rdata), v ? 32'(mq[0].data) : 32'd0);
    chk("rsp_err",   32'(bus.rsp_err),   v ? 32'(mq[0].err)  : 32'd0);
    chk("wr_cnt",    32'(bus.wr_cnt),    32'(m_wr));
    chk("rd_cnt",    32'(bus.rd_cnt),    32'(m_rd));
  endtask

  // One clock cycle: drive at the falling edge, predict the rising edge, check after it.
  task automatic step(input bit rst, input bit v, input bit we, input bit oe,
                      input bit [7:0] addr, input bit [7:0] wd, input bit rr);
    rsp_t item;
    bit   acc, pop, push;
    reset         = rst;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_oe    = oe;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.rsp_ready = rr;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(!rst && mq.size() < 2));
    if (rst) begin
      mq.delete();
      m_wr = 0;
      m_rd = 0;
    end else begin
      pop  = (mq.size() > 0) && rr;
      acc  = v && (mq.size() < 2);
      push = 0;
      if (acc && we) begin
        if (addr < DEPTH) begin
          mmem[addr[3:0]] = wd;
          m_wr++;
        end
      end else if (acc && oe) begin
        push      = 1;
        item.err  = (addr >= DEPTH);
        item.data = item.err ? 8'd0 : mmem[addr[3:0]];
        m_rd++;
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(item);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit rr);
    step(0, 0, 0, 0, 8'd0, 8'd0, rr);
  endtask

  // Hold a request until the responder takes it.
  task automatic issue(input bit we, input bit oe, input bit [7:0] a, input bit [7:0] d, input bit rr);
    bit done = 0;
    for (int k = 0; k < 8 && !done; k++) begin
      done = (mq.size() < 2);
      step(0, 1, we, oe, a, d, rr);
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && mq.size() != 0; k++) idle(1);
    chk("drain_empty", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_oe = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 0;
    @(negedge clk);

    // Reset held three cycles, then ready returns.
    for (int k = 0; k < 3; k++) step(1, 1, 0, 1, 8'd0, 8'd0, 1);
    idle(1);

    // Burst write 0..3, read back with consumer always ready.
    for (int k = 0; k < 4; k++) issue(1, 0, 8'(k), 8'(2 * (k + 1)), 1);
    for (int k = 0; k < 4; k++) begin
      issue(0, 1, 8'(k), 8'd0, 1);
      chk("burst_rdata", 32'(bus.rsp_rdata), 32'(2 * (k + 1)));
    end
    drain();
    chk("burst_wr_cnt", 32'(bus.wr_cnt), 32'd4);
    chk("burst_rd_cnt", 32'(bus.rd_cnt), 32'd4);

    // Backpressure: third read held until queue space returns.
    step(0, 1, 0, 1, 8'd1, 8'd0, 0);
    step(0, 1, 0, 1, 8'd2, 8'd0, 0);
    step(0, 1, 0, 1, 8'd3, 8'd0, 0);
    step(0, 1, 0, 1, 8'd3, 8'd0, 0);
    chk("full_ready", 32'(bus.req_ready), 32'd0);
    chk("frozen_rdata", 32'(bus.rsp_rdata), 32'd4);
    issue(0, 1, 8'd3, 8'd0, 1);
    drain();

    // Write wins over read; no-op accepted silently.
    issue(1, 1, 8'd5, 8'hA5, 1);
    chk("we_oe_no_rsp", 32'(bus.rsp_valid), 32'd0);
    issue(0, 1, 8'd5, 8'd0, 1);
    chk("we_oe_readback", 32'(bus.rsp_rdata), 32'hA5);
    drain();
    issue(0, 0, 8'd5, 8'd0, 1);
    chk("noop_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // Out-of-range write dropped, read flagged.
    issue(1, 0, 8'd20, 8'h55, 1);
    issue(0, 1, 8'd20, 8'd0, 1);
    chk("oor_valid", 32'(bus.rsp_valid), 32'd1);
    chk("oor_err",   32'(bus.rsp_err),   32'd1);
    chk("oor_rdata", 32'(bus.rsp_rdata), 32'd0);
    drain();

    // Reset discards queued responses; RAM survives.
    issue(0, 1, 8'd1, 8'd0, 0);
    issue(0, 1, 8'd2, 8'd0, 0);
    step(1, 0, 0, 0, 8'd0, 8'd0, 1);
    idle(1);
    issue(0, 1, 8'd0, 8'd0, 1);
    chk("survive_rdata", 32'(bus.rsp_rdata), 32'd2);
    drain();

    // Fill every word so random reads are fully determined.
    for (int k = 0; k < DEPTH; k++) issue(1, 0, 8'(k), 8'($urandom_range(0, 255)), 1);

    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0,
           8'($urandom_range(0, 31)),
           8'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
